prefetch_fill: RTL and testbench
================================

# prefetch_fill

Instruction prefetch filler: the writer side of the byte-wide instruction queue FIFO. It tracks the linear fetch address, issues word-aligned 16-bit memory reads over a request/ready bus handshake whenever the queue has room, and pushes the returned bytes into the FIFO write port one byte per cycle. It sits in the bus interface unit between the memory bus arbiter and the instruction queue FIFO. A flush from the execution unit, issued on a jump, clears the queue and restarts fetching at a new address.

## Interface
- WIDTH_ADDRESS, 20, linear address width
- QUEUE_DEPTH, 6, instruction queue capacity in bytes
- RESET_ADDRESS, 20'hFFFF0, fetch address after reset
- WIDTH_FREE, $clog2(QUEUE_DEPTH+1), width of queue_free
---
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low (asserted at 0)
- flush  input  1  one-cycle pulse: discard queue, restart at flush_address
- flush_address  input  WIDTH_ADDRESS  new fetch address, sampled with flush
- queue_free  input  WIDTH_FREE  free byte slots in FIFO (DEPTH minus stored count)
- queue_write_enable  output  1  FIFO write strobe, one byte per asserted cycle
- queue_write_data  output  8  byte to FIFO
- queue_clear  output  1  one-cycle FIFO clear pulse
- bus_request  output  1  memory read request, held until bus_ready
- bus_address  output  WIDTH_ADDRESS  word-aligned read address (bit 0 always 0)
- bus_ready  input  1  read complete this cycle; bus_read_data valid
- bus_read_data  input  16  read word: low byte = even address

## Operation
- Registers: fetch_address (WIDTH_ADDRESS), data_latch (16), state.
- States: IDLE, REQUEST, DRAIN, PUSH_LOW, PUSH_HIGH.
- IDLE→REQUEST: when queue_free >= 2 (fetch_address even) or queue_free >= 1 (odd). bus_address <= {fetch_address[W-1:1],1'b0}.
- REQUEST: bus_request high. On bus_ready, latch bus_read_data. Next state is PUSH_LOW if fetch_address is even, PUSH_HIGH if odd.
- PUSH_LOW: queue_write_enable=1, data=data_latch[7:0]; → PUSH_HIGH.
- PUSH_HIGH: queue_write_enable=1, data=data_latch[15:8]; fetch_address <= (fetch_address | 1) + 1; → IDLE.
- Address arithmetic is modulo 2^WIDTH_ADDRESS: 20'hFFFFF advances to 20'h00000.
- Flush takes priority over every other event:
  - queue_clear pulses high for the next cycle.
  - fetch_address <= flush_address.
  - From IDLE, PUSH_LOW or PUSH_HIGH: → IDLE. Any remaining push is aborted.
  - From REQUEST with bus_ready low: → DRAIN.
  - From REQUEST with bus_ready high: the word is discarded; → IDLE.
- DRAIN: bus_request stays high, because a bus cycle is never abandoned. On bus_ready, data is discarded; → IDLE. A flush in DRAIN reloads fetch_address and re-pulses queue_clear, and the state stays DRAIN.
- No FIFO writes occur in the cycle queue_clear is high.
- The reader may pop concurrently. queue_free only grows from pops, so no overflow is possible.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset (async, reset=0): state=IDLE, fetch_address=RESET_ADDRESS. bus_request=0, bus_address=0, queue_write_enable=0, queue_write_data=0, queue_clear=0.
- First request after reset release: bus_request rises at edge 1 (a decision edge, then a registered output) when queue_free is sufficient.
- Zero-wait read sequence:
  - request cycle, then PUSH_LOW cycle, then PUSH_HIGH cycle, then IDLE.
  - Next request rises one cycle after PUSH_HIGH at the earliest: 4 cycles per word.
- Wait states: bus_request and bus_address hold stable until the cycle bus_ready is sampled high. bus_request drops on the following edge.
- Flush: queue_clear is high exactly one cycle, the cycle after the flush edge. A request from the new address can start at the earliest the cycle after queue_clear.
- Reset asserted mid-transaction: immediate return to reset values. The bus arbiter is also reset by the same reset.

## Test plan
- Reset, queue_free=6, zero-wait bus returning 16'hEA90 at FFFF0 → bus_address=FFFF0; writes 90 then EA; next bus_address=FFFF2.
- flush with flush_address=00101, queue_free=6, read data 16'h3412 at 00100 → queue_clear 1 cycle; single write 34; next bus_address=00102.
- queue_free=1, fetch_address even → no bus_request. Raise queue_free to 2 → request issued.
- flush during REQUEST with 3 wait states, flush_address=00200 → DRAIN; bus_request held until bus_ready; no FIFO writes; next bus_address=00200.
- flush in PUSH_LOW cycle → PUSH_HIGH byte never written; queue_clear 1 cycle; restart at flush_address.
- fetch_address=FFFFF, data 16'hCC55 at FFFFE → single write CC; next bus_address=00000.

Source files
------------

// File: rtl/prefetch_fill.sv
// rtl/prefetch_fill.sv - instruction prefetch filler, writer side of the byte-wide instruction queue
//
// Ports:
//   clock              single clock, all state on rising edge
//   reset              asynchronous, active-low
//   flush              one-cycle pulse: discard queue, restart fetching at flush_address
//   flush_address      new fetch address, sampled with flush
//   queue_free         free byte slots in the instruction queue
//   queue_write_enable queue write strobe, one byte per asserted cycle
//   queue_write_data   byte written to the queue
//   queue_clear        one-cycle queue clear pulse
//   bus_request        memory read request, held until bus_ready
//   bus_address        word-aligned read address
//   bus_ready          read completes this cycle, bus_read_data valid
//   bus_read_data      read word, low byte at the even address
module prefetch_fill #(
  parameter int WIDTH_ADDRESS = 20,
  parameter int QUEUE_DEPTH = 6,
  parameter logic [WIDTH_ADDRESS-1:0] RESET_ADDRESS = 20'hFFFF0,
  parameter int WIDTH_FREE = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH_ADDRESS-1:0] flush_address,
  input  logic [WIDTH_FREE-1:0]    queue_free,
  output logic                     queue_write_enable,
  output logic [7:0]               queue_write_data,
  output logic                     queue_clear,
  output logic                     bus_request,
  output logic [WIDTH_ADDRESS-1:0] bus_address,
  input  logic                     bus_ready,
  input  logic [15:0]              bus_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    DRAIN,
    PUSH_LOW,
    PUSH_HIGH
  } state_t;

  localparam logic [WIDTH_FREE:0]    FREE_ONE = (WIDTH_FREE + 1)'(1);
  localparam logic [WIDTH_FREE:0]    FREE_TWO = (WIDTH_FREE + 1)'(2);
  localparam logic [WIDTH_ADDRESS-1:0] ADDRESS_ONE = WIDTH_ADDRESS'(1);

  state_t                     state;
  state_t                     state_next;
  logic [WIDTH_ADDRESS-1:0]   fetch_address;
  logic [WIDTH_ADDRESS-1:0]   fetch_next;
  logic [WIDTH_ADDRESS-1:0]   fetch_advance;
  logic [WIDTH_ADDRESS-1:0]   bus_address_next;
  logic [15:0]                data_latch;
  logic [15:0]                latch_next;
  logic                       clear_next;
  logic [WIDTH_FREE:0]        free_wide;
  logic                       room;

  // An odd fetch address only needs the high byte of its word, so one free
  // slot is enough; an even address brings in both bytes.
  assign free_wide = {1'b0, queue_free};
  assign room = fetch_address[0] ? (free_wide >= FREE_ONE) : (free_wide >= FREE_TWO);

  // Next word boundary; wraps modulo 2^WIDTH_ADDRESS.
  assign fetch_advance = {fetch_address[WIDTH_ADDRESS-1:1], 1'b1} + ADDRESS_ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fetch_address <= RESET_ADDRESS;
      data_latch    <= 16'h0000;
      bus_address   <= '0;
      queue_clear   <= 1'b0;
    end else begin
      state         <= state_next;
      fetch_address <= fetch_next;
      data_latch    <= latch_next;
      bus_address   <= bus_address_next;
      queue_clear   <= clear_next;
    end
  end

  always_comb begin
    state_next       = state;
    fetch_next       = fetch_address;
    latch_next       = data_latch;
    bus_address_next = bus_address;
    clear_next       = flush;

    case (state)
      IDLE: begin
        if (flush) begin
          fetch_next = flush_address;
        end else if (room) begin
          state_next       = REQUEST;
          bus_address_next = {fetch_address[WIDTH_ADDRESS-1:1], 1'b0};
        end
      end

      REQUEST: begin
        if (flush) begin
          // A started bus cycle must run to completion; if it has not
          // finished yet, wait for it in DRAIN and throw the word away.
          fetch_next = flush_address;
          state_next = bus_ready ? IDLE : DRAIN;
        end else if (bus_ready) begin
          latch_next = bus_read_data;
          state_next = fetch_address[0] ? PUSH_HIGH : PUSH_LOW;
        end
      end

      DRAIN: begin
        if (flush) begin
          fetch_next = flush_address;
        end else if (bus_ready) begin
          state_next = IDLE;
        end
      end

      PUSH_LOW: begin
        if (flush) begin
          fetch_next = flush_address;
          state_next = IDLE;
        end else begin
          state_next = PUSH_HIGH;
        end
      end

      PUSH_HIGH: begin
        if (flush) begin
          fetch_next = flush_address;
        end else begin
          fetch_next = fetch_advance;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state only, so no input reaches an output
  // without passing through a register.
  always_comb begin
    bus_request        = (state == REQUEST) || (state == DRAIN);
    queue_write_enable = (state == PUSH_LOW) || (state == PUSH_HIGH);
    queue_write_data   = 8'h00;
    if (state == PUSH_LOW) begin
      queue_write_data = data_latch[7:0];
    end else if (state == PUSH_HIGH) begin
      queue_write_data = data_latch[15:8];
    end
  end

endmodule

// File: tb/tb_prefetch_fill.sv
// tb/tb_prefetch_fill.sv - self-checking bench for prefetch_fill
module tb_prefetch_fill;

  localparam int W     = 20;
  localparam int DEPTH = 6;
  localparam int WF    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  flush_address = '0;
  logic [WF-1:0] queue_free = WF'(DEPTH);
  logic          queue_write_enable;
  logic [7:0]    queue_write_data;
  logic          queue_clear;
  logic          bus_request;
  logic [W-1:0]  bus_address;
  logic          bus_ready = 1'b0;
  logic [15:0]   bus_read_data = 16'h0000;

  prefetch_fill #(
    .WIDTH_ADDRESS(W),
    .QUEUE_DEPTH(DEPTH),
    .RESET_ADDRESS(20'hFFFF0),
    .WIDTH_FREE(WF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .flush_address(flush_address),
    .queue_free(queue_free),
    .queue_write_enable(queue_write_enable),
    .queue_write_data(queue_write_data),
    .queue_clear(queue_clear),
    .bus_request(bus_request),
    .bus_address(bus_address),
    .bus_ready(bus_ready),
    .bus_read_data(bus_read_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: bus busy flag, stale-cycle flag, bytes owed to the queue
  logic         m_req, m_stale, m_clear;
  logic [W-1:0] m_addr, exp_fa;
  logic [7:0]   wq[$];
  int           fifo_count;
  int           waits_left;

  // Stimulus knobs
  logic         k_flush;
  logic [W-1:0] k_faddr;
  int           wait_fixed;
  int           pop_pct;
  int           cyc;

  // Observation logs
  logic [W-1:0] req_log[$];
  int           req_cyc[$];
  logic [7:0]   wr_log[$];
  int           wr_cyc[$];
  int           clr_cyc[$];
  logic         prev_req_obs;

  logic [15:0] mem_ov [logic [W-1:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'h5A;
  endfunction

  function automatic logic [15:0] mem_word(input logic [W-1:0] a);
    logic [W-1:0] key;
    key = {a[W-1:1], 1'b0};
    if (mem_ov.exists(key)) return mem_ov[key];
    return {byte_at(key | 20'd1), byte_at(key)};
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return 32'(req_log[i]);
    return 'x;
  endfunction

  function automatic int req_cyc_at(input int i);
    if (i < req_cyc.size()) return req_cyc[i];
    return -1;
  endfunction

  function automatic logic [31:0] wr_at(input int i);
    if (i < wr_log.size()) return 32'(wr_log[i]);
    return 'x;
  endfunction

  function automatic int writes_before(input int c);
    int n = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] < c) n++;
    return n;
  endfunction

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); wr_log.delete(); wr_cyc.delete(); clr_cyc.delete();
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_stale = 1'b0; m_clear = 1'b0; m_addr = '0;
    exp_fa = 20'hFFFF0; wq.delete(); fifo_count = 0; waits_left = 0;
    prev_req_obs = 1'b0;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model.
  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    logic         rdy, fl, pop, wrote, idle;
    logic [15:0]  w;
    int           need;

    chk("bus_request", 32'(bus_request), 32'(m_req));
    chk("bus_address", 32'(bus_address), 32'(m_addr));
    chk("queue_clear", 32'(queue_clear), 32'(m_clear));
    chk("write_enable", 32'(queue_write_enable), 32'(wq.size() != 0));
    if (wq.size() != 0) chk("write_data", 32'(queue_write_data), 32'(wq[0]));

    if (bus_request && !prev_req_obs) begin
      req_log.push_back(bus_address);
      req_cyc.push_back(cyc);
    end
    prev_req_obs = bus_request;
    if (queue_write_enable) begin
      wr_log.push_back(queue_write_data);
      wr_cyc.push_back(cyc);
    end
    if (queue_clear) clr_cyc.push_back(cyc);

    rdy = m_req && (waits_left == 0);
    if (m_req && waits_left > 0) waits_left--;
    fl = k_flush;
    if (fl && m_stale && rdy) fl = 1'b0;
    pop = (fifo_count > 0) && !m_clear && ($urandom_range(0, 99) < pop_pct);

    flush         = fl;
    flush_address = k_faddr;
    bus_ready     = rdy;
    bus_read_data = rdy ? mem_word(m_addr) : 16'($urandom);
    queue_free    = WF'(DEPTH - fifo_count);
    k_flush       = 1'b0;

    wrote = (wq.size() != 0);
    idle  = !m_req && !wrote;
    need  = exp_fa[0] ? 1 : 2;
    if (m_clear) fifo_count = 0;
    else fifo_count = fifo_count + (wrote ? 1 : 0) - (pop ? 1 : 0);
    if (fifo_count > DEPTH) chk("queue_overflow", 32'(fifo_count), 32'(DEPTH));
    if (wrote) void'(wq.pop_front());

    if (fl) begin
      exp_fa = k_faddr;
      wq.delete();
      if (m_req) begin
        if (rdy) begin
          m_req = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (m_req) begin
      if (rdy) begin
        m_req = 1'b0;
        if (!m_stale) begin
          w = mem_word(m_addr);
          if (!exp_fa[0]) wq.push_back(w[7:0]);
          wq.push_back(w[15:8]);
          exp_fa = {exp_fa[W-1:1], 1'b1} + 20'd1;
        end
        m_stale = 1'b0;
      end
    end else if (idle && (DEPTH - (m_clear ? fifo_count : fifo_count)) >= 0 &&
                 (int'(queue_free) >= need)) begin
      m_req  = 1'b1;
      m_addr = {exp_fa[W-1:1], 1'b0};
      waits_left = (wait_fixed >= 0) ? wait_fixed : $urandom_range(0, 3);
    end
    m_clear = fl;

    cyc++;
    @(negedge clock);
  endtask

  task automatic wait_request(input string name);
    int n0 = req_log.size();
    int b = 0;
    while (req_log.size() == n0 && b < 60) begin
      cycle();
      b++;
    end
    if (req_log.size() == n0) chk({name, "_timeout"}, 32'(b), 32'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_bus_request"}, 32'(bus_request), 32'(0));
    chk({name, "_bus_address"}, 32'(bus_address), 32'(0));
    chk({name, "_write_enable"}, 32'(queue_write_enable), 32'(0));
    chk({name, "_write_data"}, 32'(queue_write_data), 32'(0));
    chk({name, "_queue_clear"}, 32'(queue_clear), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f;
    logic [W-1:0] last_addr;

    model_reset();
    k_flush = 1'b0; k_faddr = '0; wait_fixed = 0; pop_pct = 0; cyc = 0;
    clear_logs();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");

    // Zero-wait word from the reset address
    mem_ov[20'hFFFF0] = 16'hEA90;
    reset = 1'b1;
    repeat (6) cycle();
    chk("t1_addr0", req_at(0), 32'hFFFF0);
    chk("t1_req0_cycle", 32'(req_cyc_at(0)), 32'd1);
    chk("t1_byte0", wr_at(0), 32'h90);
    chk("t1_byte1", wr_at(1), 32'hEA);
    chk("t1_write_cycle", 32'((wr_cyc.size() > 1) ? wr_cyc[1] : -1), 32'd3);
    chk("t1_addr1", req_at(1), 32'hFFFF2);
    chk("t1_req1_cycle", 32'(req_cyc_at(1)), 32'd5);

    // Flush to an odd address: only the high byte is written
    mem_ov[20'h00100] = 16'h3412;
    pop_pct = 50;
    k_flush = 1'b1; k_faddr = 20'h00101;
    cycle();
    f = cyc - 1;
    clear_logs();
    repeat (12) cycle();
    chk("t2_clear_count", 32'(clr_cyc.size()), 32'd1);
    chk("t2_clear_cycle", 32'((clr_cyc.size() > 0) ? clr_cyc[0] : -1), 32'(f + 1));
    chk("t2_addr0", req_at(0), 32'h00100);
    chk("t2_req0_cycle", 32'(req_cyc_at(0)), 32'(f + 2));
    chk("t2_byte0", wr_at(0), 32'h34);
    chk("t2_single_write", 32'(writes_before(req_cyc_at(1))), 32'd1);
    chk("t2_addr1", req_at(1), 32'h00102);

    // Let the queue fill so the filler goes quiet
    pop_pct = 0;
    repeat (30) cycle();

    // Free-space threshold at an even address
    fifo_count = 5;
    k_flush = 1'b1; k_faddr = 20'h00300;
    cycle();
    clear_logs();
    cycle();
    fifo_count = 5;
    repeat (5) cycle();
    chk("t3_no_request", 32'(req_log.size()), 32'd0);
    wait_fixed = 3;
    fifo_count = 4;
    cycle();
    cycle();
    chk("t3_request_count", 32'(req_log.size()), 32'd1);
    chk("t3_addr", req_at(0), 32'h00300);

    // Flush while the request is waiting: the bus cycle drains
    k_flush = 1'b1; k_faddr = 20'h00200;
    cycle();
    f = cyc - 1;
    clear_logs();
    wait_fixed = 0; pop_pct = 100;
    repeat (12) cycle();
    chk("t4_clear_cycle", 32'((clr_cyc.size() > 0) ? clr_cyc[0] : -1), 32'(f + 1));
    chk("t4_addr", req_at(0), 32'h00200);
    chk("t4_req_cycle", 32'(req_cyc_at(0)), 32'(f + 4));
    chk("t4_no_drain_write", 32'(writes_before(req_cyc_at(0))), 32'd0);

    // Flush in the low-byte push cycle
    wait_request("t5_wait");
    last_addr = req_log[$];
    k_flush = 1'b1; k_faddr = 20'h00A40;
    cycle();
    f = cyc - 1;
    chk("t5_low_written", 32'((wr_cyc.size() > 0) ? wr_cyc[$] : -1), 32'(f));
    chk("t5_low_byte", 32'((wr_log.size() > 0) ? wr_log[$] : 8'hxx), 32'(byte_at(last_addr)));
    clear_logs();
    repeat (10) cycle();
    chk("t5_clear_count", 32'(clr_cyc.size()), 32'd1);
    chk("t5_high_aborted", 32'(writes_before(req_cyc_at(0))), 32'd0);
    chk("t5_addr", req_at(0), 32'h00A40);
    chk("t5_req_cycle", 32'(req_cyc_at(0)), 32'(f + 2));

    // Address wrap at the top of the space
    mem_ov[20'hFFFFE] = 16'hCC55;
    k_flush = 1'b1; k_faddr = 20'hFFFFF;
    cycle();
    clear_logs();
    repeat (14) cycle();
    chk("t6_addr0", req_at(0), 32'hFFFFE);
    chk("t6_byte0", wr_at(0), 32'hCC);
    chk("t6_single_write", 32'(writes_before(req_cyc_at(1))), 32'd1);
    chk("t6_addr1", req_at(1), 32'h00000);

    // Reset asserted in the middle of a transaction
    wait_request("t7_wait");
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    flush = 1'b0; bus_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_logs();
    cyc = 0;
    repeat (8) cycle();
    chk("t7_addr0", req_at(0), 32'hFFFF0);
    chk("t7_req0_cycle", 32'(req_cyc_at(0)), 32'd1);

    // Randomized traffic: wait states, pops and flushes
    wait_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: pop_pct = 0;
          1: pop_pct = 30;
          2: pop_pct = 70;
          default: pop_pct = 100;
        endcase
      end
      k_flush = ($urandom_range(0, 24) == 0);
      k_faddr = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
